// File: rtl/ro_puf_pair_counter.sv
// ro_puf_pair_counter: gated ring-oscillator bank with pairwise edge counting.
// Define RO_SIM_MODEL_EN for behavioural rings with distinct frequencies.
`timescale 1ns/1ps
module ro_puf_pair_counter #(
  parameter int NUM_RO = 8,
  parameter int STAGES = 15,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIN_W-1:0]          win_len,
  input  logic [$clog2(NUM_RO)-1:0] sel_a,
  input  logic [$clog2(NUM_RO)-1:0] sel_b,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          count_a,
  output logic [CNT_W-1:0]          count_b,
  output logic                      response,
  output logic                      overflow
);

  localparam int SEL_W = $clog2(NUM_RO);
  localparam int ST_W  = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] NEAR =
    {{(CNT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_SETL, S_CAP
  } state_t;

  state_t            state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [ST_W-1:0]   st_q, st_d;
  logic [SEL_W-1:0]  sa_q, sa_d, sb_q, sb_d;
  logic [NUM_RO-1:0] en_q, en_d;
  logic              clr_q;
  logic              busy_q, done_q, resp_q, ovf_q;
  logic [CNT_W-1:0]  cnt_a_q, cnt_b_q;
  logic [NUM_RO-1:0] tap;
  logic [1:0]        ctap;
  logic              cnt_rst_n;
  logic [CNT_W-1:0]  ring_cnt_a, ring_cnt_b;
  logic              ring_sat_a, ring_sat_b;

  // Next-state, window/settle counters and challenge latch.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    st_d    = st_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ARM;
        win_d   = (win_len == '0) ? WIN_W'(1) : win_len;
        sa_d    = SEL_W'(int'(sel_a) % NUM_RO);
        sb_d    = SEL_W'(int'(sel_b) % NUM_RO);
      end
      S_ARM: state_d = S_RUN;
      S_RUN: if (win_q == WIN_W'(1)) begin
        state_d = S_SETL;
        st_d    = ST_W'(SETTLE - 1);
      end else begin
        win_d = win_q - WIN_W'(1);
      end
      S_SETL: if (st_q == '0) state_d = S_CAP;
              else st_d = st_q - ST_W'(1);
      S_CAP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only the two selected rings run, and only while in RUN.
  always_comb begin
    en_d = '0;
    for (int i = 0; i < NUM_RO; i++)
      en_d[i] = (state_d == S_RUN) &&
                (SEL_W'(i) == sa_d || SEL_W'(i) == sb_d);
  end

  // Control state and glitch-free registered ring enables / clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      st_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      en_q    <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      st_q    <= st_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      en_q    <= en_d;
      clr_q   <= (state_d == S_ARM);
    end
  end

  for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
`ifdef RO_SIM_MODEL_EN
    logic osc;
    // Behavioural ring: toggles every STAGES+i ns, parks low.
    always begin
      osc = 1'b0;
      wait (en_q[i]);
      while (en_q[i]) begin
        #(STAGES + i);
        if (en_q[i]) osc = ~osc;
      end
    end
    assign tap[i] = osc;
`else
    (* dont_touch = "true" *) logic [STAGES-1:0] n;
    assign #1 n[0] = ~(en_q[i] & n[STAGES-1]);
    for (genvar k = 1; k < STAGES; k++) begin : g_inv
      assign #1 n[k] = ~n[k-1];
    end
    assign tap[i] = n[STAGES-1];
`endif
  end

  assign ctap[0]   = tap[sa_q];
  assign ctap[1]   = tap[sb_q];
  assign cnt_rst_n = rst_n & ~clr_q;

  for (genvar j = 0; j < 2; j++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    // Saturating edge counter in the ring clock domain.
    always_ff @(posedge ctap[j] or negedge cnt_rst_n) begin
      if (!cnt_rst_n) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
        sat_q <= sat_q | (cnt_q == NEAR);
      end
    end
  end

  assign ring_cnt_a = g_cnt[0].cnt_q;
  assign ring_cnt_b = g_cnt[1].cnt_q;
  assign ring_sat_a = g_cnt[0].sat_q;
  assign ring_sat_b = g_cnt[1].sat_q;

  // Capture frozen counts; flags and results held until next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_q == S_CAP);
      if (state_q == S_CAP) begin
        cnt_a_q <= ring_cnt_a;
        cnt_b_q <= ring_cnt_b;
        resp_q  <= (ring_cnt_a > ring_cnt_b);
        ovf_q   <= ring_sat_a | ring_sat_b;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count_a  = cnt_a_q;
  assign count_b  = cnt_b_q;
  assign response = resp_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ro_puf_pair_counter.sv
// tb_ro_puf_pair_counter: directed vector bench for the RO PUF pair counter.
// Checks latency, counts, response, saturation, start-ignore and reset abort.
`timescale 1ns/1ps
module tb_ro_puf_pair_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] win_len = '0;
  logic [2:0]  sel_a = '0;
  logic [2:0]  sel_b = '0;
  logic        busy, done, response, overflow;
  logic [15:0] count_a, count_b;
  logic        s_busy, s_done, s_resp, s_ovf;
  logic [3:0]  s_cnt_a, s_cnt_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ro_puf_pair_counter u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .win_len(win_len), .sel_a(sel_a), .sel_b(sel_b),
    .busy(busy), .done(done),
    .count_a(count_a), .count_b(count_b),
    .response(response), .overflow(overflow)
  );

  ro_puf_pair_counter #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .win_len(win_len), .sel_a(sel_a), .sel_b(sel_b),
    .busy(s_busy), .done(s_done),
    .count_a(s_cnt_a), .count_b(s_cnt_b),
    .response(s_resp), .overflow(s_ovf)
  );

  typedef struct {
    int win;
    int sa;
    int sb;
    int lat;
    int ea;
    int eb;
    bit sat;
  } vec_t;

  function automatic int half_ns(int r);
`ifdef RO_SIM_MODEL_EN
    return 15 + r;
`else
    return 15;
`endif
  endfunction

  // Rising edges of ring r in a window of win clk cycles (10 ns).
  function automatic int edges(int win, int r);
    int w;
    int h;
    w = ((win == 0) ? 1 : win) * 10;
    h = half_ns(r);
`ifdef RO_SIM_MODEL_EN
    return (w < h) ? 0 : (w - h) / (2 * h) + 1;
`else
    return w / (2 * h);
`endif
  endfunction

  task automatic chk(string name, int act, int lo, int hi);
    total++;
    if (act < lo || act > hi)
      $display("FAIL %s: got %0d, want %0d..%0d",
               name, act, lo, hi);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then wait (bounded) for done; lat counts cycles.
  task automatic run_meas(input int win, input int sa,
                          input int sb, output int lat,
                          output bit got, output bit b1);
    win_len = 16'(win);
    sel_a   = 3'(sa);
    sel_b   = 3'(sb);
    start   = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    got   = 1'b0;
    b1    = busy;
    while (lat < 400) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  vec_t tbl [6];

  initial begin
    int lat;
    int ndone;
    int first;
    bit got;
    bit b1;
    bit exp_r;

    tbl[0] = '{96, 0, 1, 103, 0, 0, 1'b1};
    tbl[1] = '{96, 1, 0, 103, 0, 0, 1'b1};
    tbl[2] = '{50, 3, 3, 57, 0, 0, 1'b0};
    tbl[3] = '{0, 2, 5, 8, 0, 0, 1'b0};
    tbl[4] = '{1, 6, 7, 8, 0, 0, 1'b0};
    tbl[5] = '{10, 7, 0, 17, 0, 0, 1'b0};
    foreach (tbl[i]) begin
      tbl[i].ea = edges(tbl[i].win, tbl[i].sa);
      tbl[i].eb = edges(tbl[i].win, tbl[i].sb);
    end

    // Reset state.
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_done", int'(done), 0, 0);
    chk("rst_cnt_a", int'(count_a), 0, 0);
    chk("rst_cnt_b", int'(count_b), 0, 0);
    chk("rst_resp", int'(response), 0, 0);
    chk("rst_ovf", int'(overflow), 0, 0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_busy", int'(busy), 0, 0);

    foreach (tbl[i]) begin
      run_meas(tbl[i].win, tbl[i].sa, tbl[i].sb,
               lat, got, b1);
      chk($sformatf("v%0d_busy1", i), int'(b1), 1, 1);
      chk($sformatf("v%0d_done", i), int'(got), 1, 1);
      chk($sformatf("v%0d_lat", i), lat,
          tbl[i].lat, tbl[i].lat);
      chk($sformatf("v%0d_cnt_a", i), int'(count_a),
          tbl[i].ea - 1, tbl[i].ea + 1);
      chk($sformatf("v%0d_cnt_b", i), int'(count_b),
          tbl[i].eb - 1, tbl[i].eb + 1);
      chk($sformatf("v%0d_ovf", i), int'(overflow), 0, 0);
      if (tbl[i].sa == tbl[i].sb)
        chk($sformatf("v%0d_eq", i), int'(count_a),
            int'(count_b), int'(count_b));
      if (half_ns(tbl[i].sa) == half_ns(tbl[i].sb)) begin
        chk($sformatf("v%0d_resp", i), int'(response), 0, 0);
      end else if (tbl[i].ea - tbl[i].eb >= 2 ||
                   tbl[i].eb - tbl[i].ea >= 2) begin
        exp_r = (tbl[i].ea > tbl[i].eb);
        chk($sformatf("v%0d_resp", i), int'(response),
            int'(exp_r), int'(exp_r));
      end
      if (tbl[i].sat) begin
        chk($sformatf("v%0d_sat_a", i), int'(s_cnt_a), 15, 15);
        chk($sformatf("v%0d_sat_b", i), int'(s_cnt_b), 15, 15);
        chk($sformatf("v%0d_sat_ovf", i), int'(s_ovf), 1, 1);
      end
      tick();
      chk($sformatf("v%0d_pulse", i), int'(done), 0, 0);
      chk($sformatf("v%0d_busy0", i), int'(busy), 0, 0);
      chk($sformatf("v%0d_hold", i), int'(count_a),
          tbl[i].ea - 1, tbl[i].ea + 1);
    end

    // start pulsed mid-RUN must be ignored: one done, original timing.
    win_len = 16'd20;
    sel_a   = 3'd2;
    sel_b   = 3'd4;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    win_len = 16'd3;
    sel_a   = 3'd5;
    start   = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    first = 0;
    for (int c = 7; c < 90; c++) begin
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
      tick();
    end
    chk("ign_ndone", ndone, 1, 1);
    chk("ign_lat", first, 27, 27);
    chk("ign_cnt_a", int'(count_a),
        edges(20, 2) - 1, edges(20, 2) + 1);

    // Reset asserted during RUN aborts with no done pulse.
    win_len = 16'd96;
    sel_a   = 3'd0;
    sel_b   = 3'd1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #2;
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_done", int'(done), 0, 0);
    chk("abort_cnt_a", int'(count_a), 0, 0);
    chk("abort_cnt_b", int'(count_b), 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 130; c++) begin
      if (done || busy) ndone++;
      tick();
    end
    chk("abort_quiet", ndone, 0, 0);
    chk("abort_hold", int'(count_a), 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
